// File: rtl/register_file_mp.sv
// +----------------------------------------------------------------------------+
// | Module      : register_file_mp                                             |
// | Description : Multi-port register file: NUM_RD combinational read ports,   |
// |               two prioritised synchronous write ports, optional hardwired  |
// |               zero register and a post-reset clear sweep that gates ready. |
// |               Optional macro REGFILE_BYPASS_EN adds write-to-read          |
// |               forwarding in the same cycle.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module register_file_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_wr0;
  logic                w_wr1;

  // Writes only count in RUN, and never land on the hardwired zero entry.
  assign w_wr0 = (state_q == ST_RUN) && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_wr1 = (state_q == ST_RUN) && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    if (state_q == ST_INIT) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end
  end

  // Port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (w_wr0) mem_q[waddr0] <= wdata0;
        if (w_wr1) mem_q[waddr1] <= wdata1;
      end
    end
  end

  assign ready = ready_q;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_lane;

      assign w_ra = raddr[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_lane = mem_q[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (w_wr0 && (waddr0 == w_ra)) w_lane = wdata0;
        if (w_wr1 && (waddr1 == w_ra)) w_lane = wdata1;
`endif
        // Contents are not architectural until the sweep completes.
        if ((state_q == ST_INIT) || ((ZERO_REG != 0) && (w_ra == '0))) w_lane = '0;
      end

      assign rdata[k*DATA_W +: DATA_W] = w_lane;
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write / dual-read register file used by the single-cycle datapath.
- Provides NUM_RD combinational read ports and two synchronous write ports with fixed priority.
- Provides an optional hardwired-zero register 0.
- Has a reset-driven clear sequencer that zeroes every entry, one entry per cycle, and then signals ready. This lets the core hold off instruction fetch until the architectural state is known.

Parameters:
- DATA_W, 64: width of each register in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, range 1..4.
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- ready  output  1  high once the clear sweep is complete.
- we0  input  1  write enable, port 0.
- waddr0  input  ADDR_W  write address, port 0.
- wdata0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1 (higher priority).
- waddr1  input  ADDR_W  write address, port 1.
- wdata1  input  DATA_W  write data, port 1.
- raddr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].

Interface rule: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- States: INIT, RUN. The state register is 1 bit. The sweep counter clr_ptr is ADDR_W bits.
- Reset: rst high at a clk edge sets state=INIT, clr_ptr=0, ready=0. This applies in any state, including mid-sweep; the sweep restarts from 0. Storage contents are not reset directly.
- INIT, each cycle with rst low: mem[clr_ptr] <= 0, clr_ptr <= clr_ptr+1.
  - When clr_ptr == DEPTH-1: the entry is cleared, state <= RUN, ready <= 1.
  - ready therefore rises on the DEPTH-th edge after the rst-low edge (edge 32 for the default parameters).
- INIT, writes: we0/we1 are ignored; no entry other than mem[clr_ptr] changes.
- INIT, reads: every rdata lane returns 0 regardless of address.
- RUN, writes: on a clk edge, if weN=1, mem[waddrN] <= wdataN.
  - If we0 and we1 are both high and waddr0 == waddr1: port 1 data is stored; port 0 is dropped.
  - If waddr0 != waddr1: both writes commit in the same cycle.
  - ZERO_REG=1: writes to address 0 are discarded on either port.
- RUN, reads: combinational, zero latency: rdata[k] = mem[raddr[k]].
  - ZERO_REG=1 and raddr[k]==0: lane k returns 0.
  - A read of an address being written in the same cycle returns the old value (without the bypass feature); the new value is visible from the next cycle.
- ready stays high in RUN until the next rst.
- Width rules:
  - No truncation or extension; data is stored exactly DATA_W bits.
  - clr_ptr wraps to 0 after DEPTH-1, but the wrap never takes effect because the state leaves INIT at that point.
- X-safety: rdata must not be X for any address once ready=1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if raddr[k] matches an enabled write address this cycle (same ZERO_REG exclusion), rdata[k] returns that write data combinationally. When both write ports match, wdata1 takes precedence. This gives write-before-read semantics.
- Not defined: no forwarding path; same-cycle reads return the stored (old) value.
- In INIT, reads return 0 in both builds.

Test Plan:
- Reset sweep: pulse rst for 1 cycle, then hold low; ready=0 for 31 edges and 1 after edge 32; all 32 entries read 0.
- Mid-sweep reset: reassert rst at sweep cycle 10 -> ready stays 0 for 32 further edges after rst falls; writes attempted during INIT (we0=1, waddr0=5, wdata0=0xAA) leave reg5=0.
- Dual write, distinct addresses: we0 to reg3=0x1111, we1 to reg4=0x2222 in the same cycle -> next cycle reads 0x1111 and 0x2222.
- Collision: both ports write reg7 (port0 0xDEAD, port1 0xBEEF) -> reg7 reads 0xBEEF.
- Zero register: ZERO_REG=1, write reg0=0xFFFF_FFFF_FFFF_FFFF -> reads 0. With ZERO_REG=0, the same write reads back 0xFFFF_FFFF_FFFF_FFFF.
- Same-cycle read of reg9 while writing 0x55: REGFILE_BYPASS_EN defined -> 0x55 in the same cycle; undefined -> old value 0, then 0x55 next cycle.
